cache_line_ctrl: RTL and testbench
==================================

# cache_line_ctrl

Controller that sequences the single-line, 32-byte `cache` block for one requester. It tracks the line tag and valid bit and decides hit/miss. On a read miss it runs a 32-beat byte-serial line fill from backing memory through a req/ack handshake. Writes are write-through, no-allocate. It sits between the CPU-side load/store port and the `cache` instance plus the slow external byte memory.

## Interface
- `TAG_W`, 8, tag width; the CPU address is `TAG_W+5` bits: `{tag, offset[4:0]}`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  request strobe; sampled only when `busy`=0.
- `cpu_we`  in  1  1=write, 0=read; sampled with `cpu_req`.
- `cpu_addr`  in  TAG_W+5  byte address; sampled with `cpu_req`.
- `cpu_wdata`  in  8  write byte; sampled with `cpu_req`.
- `busy`  out  1  high from the cycle after acceptance until response.
- `cpu_ready`  out  1  one-cycle completion pulse (read or write).
- `cpu_rdata`  out  8  read data; valid with `cpu_ready` and held until the next read completes.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  memory write qualifier.
- `mem_addr`  out  TAG_W+5  memory byte address.
- `mem_wdata`  out  8  memory write byte.
- `mem_rdata`  in  8  memory read byte; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle acknowledge.
- `c_wren`, `c_data[7:0]`, `c_wroffset[4:0]`, `c_rdoffset[4:0]`  out  drive the `cache` instance.
- `c_q`  in  8  `cache` read byte.
- `miss_count`  out  16  read-miss counter; saturates at 0xFFFF.

## Operation
- Registers:
  - `state`
  - `line_tag[TAG_W-1:0]`
  - `line_valid`
  - `fill_cnt[4:0]`
  - latched `r_addr`, `r_we`, `r_wdata`
- A hit is `line_valid && line_tag == r_addr tag`.
- IDLE: `busy`=0. On `cpu_req`, latch `addr`/`we`/`wdata` and go to LOOKUP.
- LOOKUP, read hit: `c_rdoffset` = offset; go to RESP.
- LOOKUP, read miss:
  - Clear `line_valid`, set `fill_cnt`=0, `miss_count`+1 (saturating).
  - Go to FILL.
- LOOKUP, write hit: in the same cycle drive `c_wren`=1, `c_wroffset` = offset, `c_data` = `r_wdata`. Go to WRMEM.
- LOOKUP, write miss: go to WRMEM. The cache is untouched.
- FILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = `{r_tag, fill_cnt}`.
  - In the `mem_ack` cycle, combinationally drive `c_wren`=1, `c_wroffset` = `fill_cnt`, `c_data` = `mem_rdata`. Then increment `fill_cnt`.
  - On the ack with `fill_cnt`=31: set `line_tag` = `r_tag`, `line_valid`=1, go to RESP.
  - `mem_req` stays high across beats with no idle cycle.
- RESP: `c_rdoffset` = offset. At the cycle end, register `cpu_rdata` <= `c_q`, pulse `cpu_ready` next cycle, go to IDLE.
- WRMEM:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr` = `r_addr`, `mem_wdata` = `r_wdata`.
  - On `mem_ack`: pulse `cpu_ready` next cycle, go to IDLE.
- Outside the stated cycles, `c_wren`=0 and `mem_req`=0.
- `cpu_req` while `busy`=1 is ignored; the requester must hold or retry.

## Timing
- Reset values:
  - `state` = IDLE, `line_valid`=0, `line_tag`=0, `fill_cnt`=0.
  - Outputs: `busy`=0, `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Cache port: `c_wren`=0, offsets 0, `c_data`=0.
  - `miss_count`=0.
- Reset mid-FILL or mid-WRMEM aborts the transaction:
  - `mem_req` is 0 in the first cycle after reset.
  - The line is left invalid.
  - No `cpu_ready` is issued.
- `cpu_ready` is asserted in IDLE, so a new `cpu_req` is acceptable in the `cpu_ready` cycle.
- Read hit: request at cycle 0 → LOOKUP 1 → RESP 2 → `cpu_ready` at cycle 3.
- Read miss with 0-wait ack (ack in the first FILL cycle of each beat): `cpu_ready` at cycle 3 + 32 = 35.
- Write with 0-wait ack: `cpu_ready` at cycle 3.
- The cache RAM is clocked on `~clk`, so its writes land mid-cycle.
  - RESP always follows the last cache write by at least one cycle, so `c_q` reflects the new data. No read-during-write hazard is permitted.
  - A write-hit update in LOOKUP is visible to any later read.
- A stalled `mem_ack` extends FILL/WRMEM indefinitely. All `mem_*` outputs stay stable while `mem_req`=1.

## Test plan
- Reset, then read 0x0105 with memory returning byte = addr[7:0]^0xA5:
  - 32 fill beats at addresses 0x0100..0x011F.
  - `cpu_rdata`=0xA0, `miss_count`=1.
- Read 0x0110 immediately after → hit, no `mem_req`, `cpu_ready` 3 cycles after request, data 0xB5.
- Write 0x0110=0x3C (hit), then read 0x0110:
  - Memory sees the write at 0x0110.
  - Read returns 0x3C with no fill.
- Write 0x0220=0x77 (miss):
  - Memory write only.
  - A following read of 0x0105 still hits.
  - A read of 0x0220 fills and increments `miss_count`.
- Random 0–3 cycle `mem_ack` delays during a fill: `mem_addr` stable while `mem_req`=1, all 32 bytes correct.
- Assert `rst` at fill beat 10:
  - `mem_req`=0 the next cycle, no `cpu_ready`.
  - A re-read of the same line misses again (`miss_count` reset to 0 then 1).

Source files
------------

// File: rtl/cache_line_ctrl_if.sv
// CPU load/store port and byte-serial backing-memory port of the single-line cache controller.
// The slave modport is the controller; the master modport is the requester plus memory.
`timescale 1ns/1ps
interface cache_line_ctrl_if #(parameter int TAG_W = 8);
  localparam int AW = TAG_W + 5;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          busy;
  logic          cpu_ready;
  logic [7:0]    cpu_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output busy, cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  busy, cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_ctrl.sv
// Single-line, 32-byte cache sequencer: hit/miss on one tag, byte-serial line fill on read miss,
// write-through / no-allocate stores.
`timescale 1ns/1ps
module cache_line_ctrl #(
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  cache_line_ctrl_if.slave bus,
  output logic            c_wren,
  output logic [7:0]      c_data,
  output logic [4:0]      c_wroffset,
  output logic [4:0]      c_rdoffset,
  input  logic [7:0]      c_q,
  output logic [15:0]     miss_count
);
  localparam int AW = TAG_W + 5;

  // state   | meaning
  // IDLE    | waiting for cpu_req, cpu_ready pulses here
  // LOOKUP  | tag compare on the latched request
  // FILL    | 32 byte reads from memory into the line
  // RESP    | cache read of the requested byte
  // WRMEM   | write-through of the store to memory
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_WRMEM  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TAG_W-1:0] line_tag_q, line_tag_d;
  logic             line_valid_q, line_valid_d;
  logic [4:0]       fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]    r_addr_q, r_addr_d;
  logic             r_we_q, r_we_d;
  logic [7:0]       r_wdata_q, r_wdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic [7:0]       cpu_rdata_q, cpu_rdata_d;
  logic [15:0]      miss_count_q, miss_count_d;

  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_wdata;

  logic [TAG_W-1:0] r_tag;
  logic [4:0]       r_off;
  logic             hit;

  assign r_tag = r_addr_q[AW-1:5];
  assign r_off = r_addr_q[4:0];
  assign hit   = line_valid_q && (line_tag_q == r_tag);

  always_comb begin
    state_d      = state_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    fill_cnt_d   = fill_cnt_q;
    r_addr_d     = r_addr_q;
    r_we_d       = r_we_q;
    r_wdata_d    = r_wdata_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    miss_count_d = miss_count_q;
    c_wren       = 1'b0;
    c_data       = 8'h00;
    c_wroffset   = 5'd0;
    c_rdoffset   = 5'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          r_addr_d  = bus.cpu_addr;
          r_we_d    = bus.cpu_we;
          r_wdata_d = bus.cpu_wdata;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        c_rdoffset = r_off;
        if (r_we_q) begin
          // Write hit updates the line now so any later read sees the new byte.
          if (hit) begin
            c_wren     = 1'b1;
            c_wroffset = r_off;
            c_data     = r_wdata_q;
          end
          state_d = ST_WRMEM;
        end else if (hit) begin
          state_d = ST_RESP;
        end else begin
          line_valid_d = 1'b0;
          fill_cnt_d   = 5'd0;
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, fill_cnt_q};
        if (bus.mem_ack) begin
          c_wren     = 1'b1;
          c_wroffset = fill_cnt_q;
          c_data     = bus.mem_rdata;
          fill_cnt_d = fill_cnt_q + 5'd1;
          if (fill_cnt_q == 5'd31) begin
            line_tag_d   = r_tag;
            line_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        c_rdoffset  = r_off;
        cpu_rdata_d = c_q;
        cpu_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_WRMEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr_q;
        mem_wdata = r_wdata_q;
        if (bus.mem_ack) begin
          cpu_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      fill_cnt_q   <= 5'd0;
      r_addr_q     <= '0;
      r_we_q       <= 1'b0;
      r_wdata_q    <= 8'h00;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      miss_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      fill_cnt_q   <= fill_cnt_d;
      r_addr_q     <= r_addr_d;
      r_we_q       <= r_we_d;
      r_wdata_q    <= r_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign miss_count    = miss_count_q;
endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: models the cache RAM and a byte memory with variable ack delay,
// checks a directed vector table, random traffic against a line-level model, and reset abort.
`timescale 1ns/1ps
module tb_cache_line_ctrl;
  localparam int TAG_W = 8;
  localparam int AW    = TAG_W + 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_line_ctrl_if #(.TAG_W(TAG_W)) bus ();

  logic        c_wren;
  logic [7:0]  c_data;
  logic [4:0]  c_wroffset, c_rdoffset;
  logic [7:0]  c_q;
  logic [15:0] miss_count;

  cache_line_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .c_wren(c_wren), .c_data(c_data), .c_wroffset(c_wroffset),
    .c_rdoffset(c_rdoffset), .c_q(c_q), .miss_count(miss_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // cache RAM: clocked on the falling edge
  logic [7:0] cram [32];
  initial for (int i = 0; i < 32; i++) cram[i] = 8'h00;
  always @(negedge clk) begin
    if (c_wren) cram[c_wroffset] <= c_data;
    c_q <= cram[c_rdoffset];
  end

  // external byte memory with random ack latency
  typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] data; } mtxn_t;
  mtxn_t      mlog [$];
  logic [7:0] bmem [0:(1<<AW)-1];
  int         max_dly = 0;
  int         stab_bad = 0;

  initial begin
    int wait_left;
    bit prev_req, prev_ack, prev_we;
    logic [AW-1:0] prev_addr;
    logic [7:0] prev_wdata;
    mtxn_t t;
    wait_left = -1; prev_req = 0; prev_ack = 0; prev_we = 0; prev_addr = '0; prev_wdata = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #2;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 8'($urandom);
      if (prev_req && !prev_ack && bus.mem_req &&
          (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we || bus.mem_wdata !== prev_wdata))
        stab_bad++;
      if (bus.mem_req && !rst) begin
        if (wait_left < 0) wait_left = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          t.we = bus.mem_we;
          t.addr = bus.mem_addr;
          if (bus.mem_we) begin
            bmem[bus.mem_addr] = bus.mem_wdata;
            t.data = bus.mem_wdata;
          end else begin
            bus.mem_rdata = bmem[bus.mem_addr];
            t.data = bus.mem_rdata;
          end
          mlog.push_back(t);
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
      prev_req = bus.mem_req; prev_ack = bus.mem_ack; prev_we = bus.mem_we;
      prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata;
    end
  end

  // line-level reference model
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [7:0] m_line [32];
  bit         m_valid = 0;
  logic [7:0] m_tag = 0;
  int         m_miss = 0;

  task automatic model_txn(input bit we, input logic [AW-1:0] a, input logic [7:0] wd,
                           output bit hit, output logic [7:0] rd);
    logic [7:0] tg;
    logic [4:0] off;
    tg = a[AW-1:5];
    off = a[4:0];
    hit = m_valid && (m_tag == tg);
    rd = 8'h00;
    if (we) begin
      if (hit) m_line[off] = wd;
      ref_mem[a] = wd;
    end else begin
      if (!hit) begin
        for (int i = 0; i < 32; i++) m_line[i] = ref_mem[{tg, 5'(i)}];
        m_valid = 1;
        m_tag = tg;
        if (m_miss < 65535) m_miss++;
      end
      rd = m_line[off];
    end
  endtask

  // Issue at cycle 0 (called at posedge+1 with the DUT idle); latency counts to the cpu_ready cycle.
  // While busy, stray requests are driven to show they are ignored.
  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [7:0] wd,
                         output logic [7:0] rd, output int lat, output bit tmo);
    mlog.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(posedge clk); #1;
    lat = 1;
    while (bus.cpu_ready !== 1'b1 && lat < 1000) begin
      bus.cpu_req = 1'($urandom_range(1, 0));
      bus.cpu_we = 1'($urandom_range(1, 0));
      bus.cpu_addr = AW'($urandom);
      bus.cpu_wdata = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.cpu_req = 1'b0;
    tmo = (bus.cpu_ready !== 1'b1);
    rd = bus.cpu_rdata;
  endtask

  task automatic exec(input string nm, input bit we, input logic [AW-1:0] addr, input logic [7:0] wd,
                      input bit exp_hit, input logic [7:0] exp_rd, input int exp_miss, input int exp_lat);
    logic [7:0] rd;
    int lat, bad;
    bit tmo;
    run_txn(we, addr, wd, rd, lat, tmo);
    chk({nm, ".timeout"}, 32'(tmo), 0);
    if (!we) chk({nm, ".rdata"}, 32'(rd), 32'(exp_rd));
    chk({nm, ".miss_count"}, 32'(miss_count), 32'(exp_miss));
    if (exp_lat > 0) chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    if (we) begin
      chk({nm, ".mem_txns"}, 32'(mlog.size()), 1);
      if (mlog.size() == 1)
        chk({nm, ".mem_write"}, {15'd0, 1'(mlog[0].we), 3'd0, mlog[0].addr}, {15'd0, 1'b1, 3'd0, addr});
      if (mlog.size() == 1) chk({nm, ".mem_wdata"}, 32'(mlog[0].data), 32'(wd));
    end else if (exp_hit) begin
      chk({nm, ".mem_txns"}, 32'(mlog.size()), 0);
    end else begin
      chk({nm, ".mem_txns"}, 32'(mlog.size()), 32);
      bad = 0;
      foreach (mlog[i])
        if (mlog[i].we || mlog[i].addr !== {addr[AW-1:5], 5'(i)}) bad++;
      chk({nm, ".fill_order"}, 32'(bad), 0);
    end
  endtask

  typedef struct {
    bit we; logic [AW-1:0] addr; logic [7:0] wdata;
    bit exp_hit; logic [7:0] exp_rd; int exp_miss; int exp_lat;
  } vec_t;
  vec_t vecs [9];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [7:0] erd;
    logic [AW-1:0] a;
    bit w;
    logic [7:0] wd;
    int n, rdy_seen, req_seen;

    for (int i = 0; i < (1 << AW); i++) begin
      bmem[i] = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    vecs[0] = '{0, 13'h0105, 8'h00, 0, 8'hA0, 1, 35};
    vecs[1] = '{0, 13'h0110, 8'h00, 1, 8'hB5, 1, 3};
    vecs[2] = '{1, 13'h0110, 8'h3C, 1, 8'h00, 1, 3};
    vecs[3] = '{0, 13'h0110, 8'h00, 1, 8'h3C, 1, 3};
    vecs[4] = '{1, 13'h0220, 8'h77, 0, 8'h00, 1, 3};
    vecs[5] = '{0, 13'h0100, 8'h00, 1, 8'hA5, 1, 3};
    vecs[6] = '{0, 13'h0105, 8'h00, 1, 8'hA0, 1, 3};
    vecs[7] = '{0, 13'h0220, 8'h00, 0, 8'h77, 2, 35};
    vecs[8] = '{0, 13'h0105, 8'h00, 0, 8'hA0, 3, 35};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.cpu_ready", 32'(bus.cpu_ready), 0);
    chk("reset.cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("reset.mem_req", 32'(bus.mem_req), 0);
    chk("reset.mem_we", 32'(bus.mem_we), 0);
    chk("reset.mem_addr", 32'(bus.mem_addr), 0);
    chk("reset.mem_wdata", 32'(bus.mem_wdata), 0);
    chk("reset.c_wren", 32'(c_wren), 0);
    chk("reset.c_offsets", {22'd0, c_wroffset, c_rdoffset}, 0);
    chk("reset.c_data", 32'(c_data), 0);
    chk("reset.miss_count", 32'(miss_count), 0);

    for (int i = 0; i < 9; i++) begin
      model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, h, erd);
      exec($sformatf("row%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_hit, vecs[i].exp_rd, vecs[i].exp_miss, vecs[i].exp_lat);
    end

    // stalled fill, then every byte of the line
    max_dly = 3;
    model_txn(0, 13'h00A0, 8'h00, h, erd);
    exec("dly_fill", 0, 13'h00A0, 8'h00, h, erd, m_miss, 0);
    for (int i = 0; i < 32; i++) begin
      a = {8'h05, 5'(i)};
      model_txn(0, a, 8'h00, h, erd);
      exec($sformatf("dly_byte%0d", i), 0, a, 8'h00, h, erd, m_miss, 0);
    end

    for (int k = 0; k < 40; k++) begin
      a = {8'($urandom_range(3, 1)), 5'($urandom)};
      w = ($urandom_range(9, 0) < 3);
      wd = 8'($urandom);
      model_txn(w, a, wd, h, erd);
      exec($sformatf("rnd%0d", k), w, a, wd, h, erd, m_miss, 0);
    end
    chk("mem_stable_while_req", 32'(stab_bad), 0);

    // reset during beat 10 of a fill
    max_dly = 0;
    mlog.delete();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h0305; bus.cpu_wdata = 0;
    @(posedge clk); #1;
    bus.cpu_req = 0;
    n = 0;
    while (mlog.size() < 10 && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst.beat10_reached", 32'(mlog.size()), 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.mem_req", 32'(bus.mem_req), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.miss_count", 32'(miss_count), 0);
    rdy_seen = 0; req_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_ready === 1'b1) rdy_seen++;
      if (bus.mem_req === 1'b1) req_seen++;
      @(posedge clk); #1;
    end
    chk("rst.no_cpu_ready", 32'(rdy_seen), 0);
    chk("rst.no_mem_req", 32'(req_seen), 0);
    m_valid = 0;
    m_miss = 0;
    model_txn(0, 13'h0305, 8'h00, h, erd);
    exec("rst.reread", 0, 13'h0305, 8'h00, h, erd, 1, 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
